divider_prog: RTL and testbench

Runtime-programmable integer clock divider, successor to the fixed odd-only divider in the frequency-divider lab set. It produces a 50%-duty output for both odd and even divide ratios and accepts a new ratio through a valid/ready handshake. A new ratio takes effect only at a period boundary, and start/stop is glitch-free. It feeds downstream lab blocks that need a switchable derived clock plus a period-start tick.

---
 rtl/clkdiv_pkg.sv | 15 +
 rtl/clkdiv_half_delay.sv | 28 ++
 rtl/divider_prog.sv | 167 ++++++++++++++++
 tb/tb_divider_prog.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg -- shared types and helpers for the programmable clock divider.
//   state_t        : divider FSM states (IDLE, RUN)
//   CLKDIV_MIN_DIV : smallest divide ratio the divider accepts
//   half_of(n)     : length of the posedge-domain high phase for ratio n
package clkdiv_pkg;

  typedef enum logic {IDLE, RUN} state_t;

  localparam int CLKDIV_MIN_DIV = 2;

  function automatic int unsigned half_of(input int unsigned n);
    return n >> 1;
  endfunction

endpackage

// File: rtl/clkdiv_half_delay.sv
// clkdiv_half_delay -- retimes the posedge phase register onto the falling
// edge of the source clock. This is the only negedge logic in the divider,
// kept in its own module so its timing can be reviewed in isolation.
// Ports:
//   clkin : source clock (falling edge used here)
//   rst   : asynchronous active-high reset
//   clka  : posedge-domain phase register
//   clkb  : clka delayed by half a clkin period
module clkdiv_half_delay (
  input  logic clkin,
  input  logic rst,
  input  logic clka,
  output logic clkb
);

  logic clkb_reg;

  always_ff @(negedge clkin or posedge rst) begin
    if (rst) begin
      clkb_reg <= 1'b0;
    end else begin
      clkb_reg <= clka;
    end
  end

  assign clkb = clkb_reg;

endmodule

// File: rtl/divider_prog.sv
// divider_prog -- runtime-programmable integer clock divider with 50% duty
// for both odd and even ratios. A new ratio is offered over a valid/ready
// handshake and takes effect only at a period boundary; stopping waits for
// the current period to finish so no runt pulses are produced.
// Parameters:
//   WIDTH       : width of ratio and phase counter (max ratio 2^WIDTH-1)
//   DEFAULT_DIV : ratio loaded at reset (>= 2)
// Ports:
//   clkin     : source clock, both edges used
//   rst       : asynchronous active-high reset
//   en        : run request
//   cfg_div   : requested ratio, cfg_valid qualifies it
//   cfg_ready : a ratio can be accepted (no ratio pending)
//   cfg_err   : one-cycle pulse when an offered ratio < 2 is rejected
//   clkout    : divided clock
//   clk_aout  : posedge-domain phase register (clka)
//   clk_bout  : clka retimed on the falling edge (clkb)
//   tick      : one-cycle pulse at the start of every output period
//   active    : high while running
// Optional build macro CLKDIV_PHASE_OUT_EN adds phase (counter) and
// div_cur (active ratio) outputs.
module divider_prog
  import clkdiv_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 5
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] cfg_div,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clkout,
  output logic             clk_aout,
  output logic             clk_bout,
  output logic             tick,
  output logic             active
`ifdef CLKDIV_PHASE_OUT_EN
  ,
  output logic [WIDTH-1:0] phase,
  output logic [WIDTH-1:0] div_cur
`endif
);

  if (DEFAULT_DIV < CLKDIV_MIN_DIV || DEFAULT_DIV > (2 ** WIDTH) - 1) begin : g_bad_default
    $error("divider_prog: DEFAULT_DIV must be in [2, 2^WIDTH-1]");
  end

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] n_act_reg, n_act_next;
  logic [WIDTH-1:0] pend_reg, pend_next;
  logic             clka_reg, clka_next;
  logic             tick_reg, tick_next;
  logic             cfg_err_reg, cfg_err_next;
  logic             cfg_ready_reg, cfg_ready_next;

  logic             clkb;
  logic             wrap;
  logic             accept;
  logic             apply;
  logic [WIDTH-1:0] cnt_inc;
  logic [WIDTH-1:0] half_new;

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      n_act_reg     <= WIDTH'(DEFAULT_DIV);
      pend_reg      <= '0;
      clka_reg      <= 1'b0;
      tick_reg      <= 1'b0;
      cfg_err_reg   <= 1'b0;
      cfg_ready_reg <= 1'b1;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      n_act_reg     <= n_act_next;
      pend_reg      <= pend_next;
      clka_reg      <= clka_next;
      tick_reg      <= tick_next;
      cfg_err_reg   <= cfg_err_next;
      cfg_ready_reg <= cfg_ready_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    clka_next      = clka_reg;
    tick_next      = 1'b0;
    pend_next      = pend_reg;
    cfg_ready_next = cfg_ready_reg;

    accept = cfg_valid & cfg_ready_reg;
    wrap   = (state_reg == RUN) && (cnt_reg == n_act_reg - WIDTH'(1));
    // A pending ratio exists exactly when cfg_ready is low. It is applied
    // at a period boundary in RUN, or on the very next edge in IDLE. A value
    // accepted on a wrap edge is not yet pending there, so it waits a period.
    apply  = !cfg_ready_reg && ((state_reg == IDLE) || wrap);

    n_act_next   = apply ? pend_reg : n_act_reg;
    // High-phase length uses the ratio that becomes active on this edge, so
    // the first period after a ratio change is already shaped correctly.
    half_new     = WIDTH'(half_of(32'(n_act_next)));
    cnt_inc      = wrap ? '0 : cnt_reg + WIDTH'(1);
    cfg_err_next = accept && (cfg_div < WIDTH'(CLKDIV_MIN_DIV));

    if (accept && !cfg_err_next) begin
      pend_next      = cfg_div;
      cfg_ready_next = 1'b0;
    end else if (apply) begin
      cfg_ready_next = 1'b1;
    end

    case (state_reg)
      IDLE: begin
        cnt_next  = '0;
        clka_next = 1'b0;
        if (en) begin
          state_next = RUN;
          clka_next  = 1'b1;
          tick_next  = 1'b1;
        end
      end
      RUN: begin
        if (wrap && !en) begin
          // Stop only on a period boundary so the last period is complete.
          state_next = IDLE;
          cnt_next   = '0;
          clka_next  = 1'b0;
        end else begin
          cnt_next  = cnt_inc;
          clka_next = (cnt_inc < half_new);
          tick_next = (cnt_inc == '0);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  clkdiv_half_delay u_half_delay (
    .clkin (clkin),
    .rst   (rst),
    .clka  (clka_reg),
    .clkb  (clkb)
  );

  // Odd ratios stretch the high phase by half a clkin period using clkb.
  assign clkout    = n_act_reg[0] ? (clka_reg | clkb) : clka_reg;
  assign clk_aout  = clka_reg;
  assign clk_bout  = clkb;
  assign tick      = tick_reg;
  assign active    = (state_reg == RUN);
  assign cfg_ready = cfg_ready_reg;
  assign cfg_err   = cfg_err_reg;

`ifdef CLKDIV_PHASE_OUT_EN
  assign phase   = cnt_reg;
  assign div_cur = n_act_reg;
`endif

endmodule

// File: tb/tb_divider_prog.sv
// tb_divider_prog -- scoreboard bench for divider_prog. Stimulus pushes the
// ratio expected for every output period into a queue; a monitor measures
// each period (clkin cycles, high half-cycles of clkout, high cycles of
// clk_aout) and compares it against the popped ratio.
module tb_divider_prog;

  localparam int WIDTH = 8;

  logic             clkin = 1'b0;
  logic             rst;
  logic             en;
  logic [WIDTH-1:0] cfg_div;
  logic             cfg_valid;
  logic             cfg_ready;
  logic             cfg_err;
  logic             clkout;
  logic             clk_aout;
  logic             clk_bout;
  logic             tick;
  logic             active;
`ifdef CLKDIV_PHASE_OUT_EN
  logic [WIDTH-1:0] phase;
  logic [WIDTH-1:0] div_cur;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];

  always #5 clkin = ~clkin;

  divider_prog #(.WIDTH(WIDTH), .DEFAULT_DIV(5)) dut (
    .clkin     (clkin),
    .rst       (rst),
    .en        (en),
    .cfg_div   (cfg_div),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .clkout    (clkout),
    .clk_aout  (clk_aout),
    .clk_bout  (clk_bout),
    .tick      (tick),
    .active    (active)
`ifdef CLKDIV_PHASE_OUT_EN
    ,
    .phase     (phase),
    .div_cur   (div_cur)
`endif
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: one sample half a cycle apart (posedge+1, negedge+1).
  initial begin : monitor
    bit in_period;
    int cyc_cnt, hi_cnt, a_cnt, exp_n;
    in_period = 0;
    cyc_cnt = 0;
    hi_cnt = 0;
    a_cnt = 0;
    forever begin
      @(posedge clkin);
      #1;
      if (rst) begin
        in_period = 0;
      end else begin
        if (in_period && (tick || !active)) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL period_unexpected: got a period of %0d cycles, required none", cyc_cnt);
          end else begin
            exp_n = exp_q.pop_front();
            $display("period: N=%0d cycles=%0d high_halfcycles=%0d clka_high=%0d",
                     exp_n, cyc_cnt, hi_cnt, a_cnt);
            check("period_cycles", cyc_cnt, exp_n);
            check("clkout_high_halfcycles", hi_cnt, exp_n);
            check("clka_high_cycles", a_cnt, exp_n / 2);
          end
        end
        if (tick) begin
          in_period = 1;
          cyc_cnt = 0;
          hi_cnt = 0;
          a_cnt = 0;
        end else if (!active) begin
          in_period = 0;
        end
        if (in_period) begin
          cyc_cnt++;
          hi_cnt += int'(clkout);
          a_cnt += int'(clk_aout);
        end
      end
      @(negedge clkin);
      #1;
      if (rst) in_period = 0;
      else if (in_period) hi_cnt += int'(clkout);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clkin);
  endtask

  task automatic wait_tick(input string what);
    int k = 0;
    do begin
      @(negedge clkin);
      cfg_valid = 1'b0;
      k++;
    end while (!tick && k < 64);
    check({"tick_", what}, int'(tick), 1);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (active && k < 64) begin
      @(negedge clkin);
      k++;
    end
    check("stop_reached", int'(active), 0);
    #1;
    check("stop_clkout", int'(clkout), 0);
    check("stop_clka", int'(clk_aout), 0);
  endtask

  // Program n in IDLE, run 4 periods, offer m at counter value c of the
  // second period, stop during the fourth. A ratio accepted on a wrap edge
  // only takes effect one period later.
  task automatic run_iter(input int n, input int m, input int c, input bit sim);
    @(negedge clkin);
    $display("iter: N=%0d M=%0d offer_at=%0d en_with_apply=%0d", n, m, c, sim);
    exp_q.push_back(n);
    exp_q.push_back(n);
    exp_q.push_back((c == n - 1) ? n : m);
    exp_q.push_back(m);
    cfg_div = WIDTH'(n);
    cfg_valid = 1'b1;
    @(negedge clkin);
    cfg_valid = 1'b0;
    check("idle_accept_ready", int'(cfg_ready), 0);
    if (sim) en = 1'b1;
    @(negedge clkin);
    check("idle_apply_ready", int'(cfg_ready), 1);
    if (!sim) begin
      en = 1'b1;
      @(negedge clkin);
    end
    check("start_tick", int'(tick), 1);
    check("start_active", int'(active), 1);
    wait_tick("p1");
    cyc(c);
    cfg_div = WIDTH'(m);
    cfg_valid = 1'b1;
    wait_tick("p2");
    check("ready_at_p2", int'(cfg_ready), (c == n - 1) ? 0 : 1);
    wait_tick("p3");
    check("ready_at_p3", int'(cfg_ready), 1);
    cyc(1);
    en = 1'b0;
    wait_idle();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int n, m, c;
    rst = 1'b1;
    en = 1'b1;
    cfg_valid = 1'b0;
    cfg_div = '0;

    // Reset held three cycles with en high: everything quiet.
    for (int i = 0; i < 3; i++) begin
      @(negedge clkin);
      #1;
      check("rst_clkout", int'(clkout), 0);
      check("rst_clka", int'(clk_aout), 0);
      check("rst_clkb", int'(clk_bout), 0);
      check("rst_tick", int'(tick), 0);
      check("rst_active", int'(active), 0);
      check("rst_cfg_ready", int'(cfg_ready), 1);
      check("rst_cfg_err", int'(cfg_err), 0);
    end
    @(negedge clkin);
    rst = 1'b0;
    exp_q.push_back(5);
    exp_q.push_back(5);
    exp_q.push_back(5);
    @(negedge clkin);
    check("first_tick", int'(tick), 1);
    check("first_active", int'(active), 1);
    cyc(1);
    // Invalid ratios 1 then 0: rejected, ratio stays 5.
    cfg_div = 8'd1;
    cfg_valid = 1'b1;
    @(negedge clkin);
    check("err_div1", int'(cfg_err), 1);
    check("err_div1_ready", int'(cfg_ready), 1);
    cfg_div = 8'd0;
    @(negedge clkin);
    check("err_div0", int'(cfg_err), 1);
    check("err_div0_ready", int'(cfg_ready), 1);
    cfg_valid = 1'b0;
    @(negedge clkin);
    check("err_pulse_end", int'(cfg_err), 0);
    wait_tick("a1");
    wait_tick("a2");
    cyc(1);
    en = 1'b0;
    wait_idle();

    run_iter(4, 4, 2, 0);
    run_iter(5, 6, 1, 0);
    run_iter(4, 7, 2, 0);
    run_iter(3, 2, 2, 1);
    run_iter(2, 3, 1, 1);

    // Asynchronous reset in the middle of a high phase at N=9.
    @(negedge clkin);
    cfg_div = 8'd9;
    cfg_valid = 1'b1;
    @(negedge clkin);
    cfg_valid = 1'b0;
    en = 1'b1;
    exp_q.push_back(9);
    @(negedge clkin);
    check("n9_tick", int'(tick), 1);
    wait_tick("n9_p1");
    cyc(2);
    #2;
    check("n9_high_before_rst", int'(clk_aout), 1);
    rst = 1'b1;
    #1;
    check("async_rst_clkout", int'(clkout), 0);
    check("async_rst_clka", int'(clk_aout), 0);
    check("async_rst_clkb", int'(clk_bout), 0);
    check("async_rst_active", int'(active), 0);
    check("async_rst_ready", int'(cfg_ready), 1);
    en = 1'b0;
    cyc(2);
    rst = 1'b0;
    en = 1'b1;
    exp_q.push_back(5);
    exp_q.push_back(5);
    @(negedge clkin);
    check("post_rst_tick", int'(tick), 1);
    wait_tick("post_rst_p1");
    cyc(1);
    en = 1'b0;
    wait_idle();

    for (int i = 0; i < 8; i++) begin
      n = $urandom_range(2, 20);
      m = $urandom_range(2, 20);
      c = $urandom_range(0, n - 1);
      run_iter(n, m, c, 1'($urandom_range(0, 1)));
    end

    cyc(4);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
